// File: rtl/tile_config_mem_shadow_if.sv
// Column configuration bus as seen by one tile: frame write port,
// commit pulse, readback select, and the tile's configuration outputs.
interface tile_config_mem_shadow_if #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NoConfigBits    = 40
);
  localparam int SelW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;

  logic [FrameBitsPerRow-1:0] FrameData;
  logic [MaxFramesPerCol-1:0] FrameStrobe;
  logic                       Commit;
  logic [SelW-1:0]            ReadFrameSel;
  logic [NoConfigBits-1:0]    ConfigBits;
  logic [NoConfigBits-1:0]    ConfigBits_N;
  logic                       FramesLoaded;
  logic                       StrobeError;
  logic [FrameBitsPerRow-1:0] ReadFrameData;

  // Bus master: drives frames, commit and readback select.
  modport master (
    output FrameData, FrameStrobe, Commit, ReadFrameSel,
    input  ConfigBits, ConfigBits_N, FramesLoaded, StrobeError, ReadFrameData
  );

  // Tile configuration memory.
  modport slave (
    input  FrameData, FrameStrobe, Commit, ReadFrameSel,
    output ConfigBits, ConfigBits_N, FramesLoaded, StrobeError, ReadFrameData
  );
endinterface

// File: rtl/tile_config_mem_shadow.sv
// Shadowed per-tile configuration memory. Frames are captured into a
// staging register and copied atomically into the active ConfigBits on a
// Commit pulse, so live logic never sees a partially loaded configuration.
module tile_config_mem_shadow #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NoConfigBits    = 40
) (
  input logic                   CLK,
  input logic                   reset,
  tile_config_mem_shadow_if.slave bus
);
  localparam int UsedFrames = (NoConfigBits + FrameBitsPerRow - 1) / FrameBitsPerRow;
  localparam int SelW       = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int PadW       = UsedFrames * FrameBitsPerRow;

  logic [NoConfigBits-1:0]    staging_q, staging_d;
  logic [NoConfigBits-1:0]    active_q, active_d;
  logic [UsedFrames-1:0]      loaded_q, loaded_d;
  logic                       strobe_err_q, strobe_err_d;
  logic [FrameBitsPerRow-1:0] rd_q, rd_d;

  logic                       multi_hot;
  logic                       write_en;
  logic [UsedFrames-1:0]      write_sel;
  logic [PadW-1:0]            staging_pad;

  // Padding bits of the last partial frame are never stored; fold them away.
  logic unused_frame_bits;
  assign unused_frame_bits = ^bus.FrameData;

  // Classify the strobe: two or more bits set is illegal; a single bit
  // outside the used frames selects nothing and is silently ignored.
  always_comb begin
    multi_hot = (bus.FrameStrobe & (bus.FrameStrobe - MaxFramesPerCol'(1))) != '0;
    write_sel = bus.FrameStrobe[UsedFrames-1:0];
    write_en  = !multi_hot && (write_sel != '0);
  end

  // Next staging: overwrite the strobed frame, dropping bits past NoConfigBits.
  always_comb begin
    staging_d = staging_q;
    for (int i = 0; i < NoConfigBits; i++) begin
      if (write_en && write_sel[i / FrameBitsPerRow]) begin
        staging_d[i] = bus.FrameData[i % FrameBitsPerRow];
      end
    end
  end

  // Commit copies staging including any same-cycle write, and restarts the
  // loaded tracker; the error flag only accumulates.
  always_comb begin
    active_d     = bus.Commit ? staging_d : active_q;
    loaded_d     = bus.Commit ? '0 : (loaded_q | (write_en ? write_sel : '0));
    strobe_err_d = strobe_err_q | multi_hot;
  end

  // Readback of the pre-write staging frame; zero padding covers both the
  // tail of the last frame and out-of-range selects.
  assign staging_pad = PadW'(staging_q);
  always_comb begin
    rd_d = '0;
    for (int f = 0; f < UsedFrames; f++) begin
      if (bus.ReadFrameSel == SelW'(f)) begin
        rd_d = staging_pad[f*FrameBitsPerRow +: FrameBitsPerRow];
      end
    end
  end

  // State registers; reset wins over any write or commit in the same cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      staging_q    <= '0;
      active_q     <= '0;
      loaded_q     <= '0;
      strobe_err_q <= 1'b0;
      rd_q         <= '0;
    end else begin
      staging_q    <= staging_d;
      active_q     <= active_d;
      loaded_q     <= loaded_d;
      strobe_err_q <= strobe_err_d;
      rd_q         <= rd_d;
    end
  end

  assign bus.ConfigBits    = active_q;
  assign bus.ConfigBits_N  = ~active_q;
  assign bus.FramesLoaded  = &loaded_q;
  assign bus.StrobeError   = strobe_err_q;
  assign bus.ReadFrameData = rd_q;
endmodule

// File: doc/tile_config_mem_shadow.md
# tile_config_mem_shadow

Parametrised, clocked successor to the per-tile frame-latch configuration memory. It captures configuration frames from the column FrameData/FrameStrobe bus into a staging register and transfers them atomically to the active ConfigBits on a commit pulse, so that tiles can be reconfigured without glitching live logic. It adds a frame-loaded tracker, strobe-error detection and a registered per-frame readback port. One instance sits in each tile with NoConfigBits >= 1; terminal tiles with no configuration bits do not instantiate it.

## Interface
Parameters:
- MaxFramesPerCol, 20: FrameStrobe width (frames per column).
- FrameBitsPerRow, 32: FrameData width (bits per frame).
- NoConfigBits, 40: tile configuration bits; 1 <= NoConfigBits <= MaxFramesPerCol*FrameBitsPerRow.
- Derived UsedFrames = ceil(NoConfigBits/FrameBitsPerRow); SelW = max(1, clog2(MaxFramesPerCol)).

Ports:
- Clock and reset (already decided): single clock CLK; reset is synchronous and active-high on port reset.
- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous active-high reset.
- FrameData  in  FrameBitsPerRow  frame payload.
- FrameStrobe  in  MaxFramesPerCol  one-hot frame write select, sampled each cycle.
- Commit  in  1  single-cycle pulse that copies staging to active.
- ConfigBits  out  NoConfigBits  active configuration.
- ConfigBits_N  out  NoConfigBits  bitwise inverse of ConfigBits.
- FramesLoaded  out  1  high when every used frame has been written since the last commit or reset.
- StrobeError  out  1  sticky flag for an illegal strobe.
- ReadFrameSel  in  SelW  frame index for readback.
- ReadFrameData  out  FrameBitsPerRow  registered readback of the staging frame.

## Operation
- Bit mapping: config bit i = frame i/FrameBitsPerRow, FrameData bit i%FrameBitsPerRow. In the last partial frame, FrameData bits beyond NoConfigBits are dropped.
- Write: a cycle with exactly one FrameStrobe bit k set, where k < UsedFrames, loads frame k of staging from FrameData and sets loaded[k].
  - A single strobe bit with k >= UsedFrames is ignored: no write, no error.
- Illegal strobe: two or more FrameStrobe bits set. No staging write occurs, and StrobeError is set. StrobeError is cleared only by reset.
- Commit: on the edge where Commit=1, active <= staging merged with any legal write in the same cycle, and loaded[] clears to all zero (a same-cycle write counts as committed).
  - Commit is accepted regardless of FramesLoaded.
- FramesLoaded = AND of loaded[0..UsedFrames-1], combinational from the loaded register.
- ConfigBits is driven directly from the active register. ConfigBits_N = ~ConfigBits, combinational.
- Readback: ReadFrameData <= staging frame ReadFrameSel, sampled before this edge's write.
  - Bits beyond NoConfigBits in the last frame read 0.
  - ReadFrameSel >= UsedFrames reads all zero.
- Staging is never cleared by commit; frames not rewritten keep their prior values.

## Timing
- Reset values: staging=0, active=0, ConfigBits=0, ConfigBits_N=all ones, loaded=0, FramesLoaded=0, StrobeError=0, ReadFrameData=0.
- Reset has priority over write and commit in the same cycle. Reset mid-load discards the partial load and does not perform a commit.
- Write latency: staging updates at the strobe edge; a readback of that frame sees the new data when sampled one cycle later, visible after one more edge.
- Commit latency: ConfigBits changes exactly one edge after Commit is sampled high and is otherwise stable. No partial update is ever visible.
- Back-to-back strobes on consecutive cycles are supported at full rate; the last write to a frame wins.
- Commit on consecutive cycles is legal; the second commit copies the unchanged staging (idempotent).
- No handshake: the bus master guarantees data and strobe are valid in the cycle they are presented.

## Test plan
Parameters for all scenarios: NoConfigBits=40, FrameBitsPerRow=32, MaxFramesPerCol=20, giving UsedFrames=2.
- Reset, then idle -> ConfigBits=0, ConfigBits_N=40'hFF_FFFF_FFFF, FramesLoaded=0, StrobeError=0.
- Write frame0=32'hDEADBEEF, then frame1=32'h000000A5, then Commit -> FramesLoaded=1 before commit and 0 after; one edge after commit, ConfigBits=40'hA5_DEADBEEF.
- Write frame1=32'hFFFFFF3C, then read frame1 -> ReadFrameData=32'h0000003C.
- FrameStrobe=20'h00003 with any data -> StrobeError=1 and stays 1; staging unchanged; ConfigBits unchanged after a subsequent commit.
- Write frame0=32'h12345678 in the same cycle as Commit -> ConfigBits[31:0]=32'h12345678 one edge later; FramesLoaded=0.
- Strobe bit 7 (unused frame) with data 32'hFFFFFFFF -> no state change, StrobeError=0. Then reset asserted together with Commit -> all outputs return to reset values.
